// File: rtl/leds_controller.sv
// rtl/leds_controller.sv - memory-mapped LED value/mode/blink-period registers
// with a hardware blink engine driving the board LEDs.
module leds_controller #(
  parameter int          LED_WIDTH        = 16,
  parameter logic [31:0] BLINK_PERIOD_RST = 32'd10_000_000
) (
  input  logic                 clk_i,
  input  logic                 arstn_i,
  input  logic                 we_i,
  input  logic [31:0]          addr_i,
  input  logic [31:0]          wdata_i,
  output logic [31:0]          rdata_o,
  output logic [LED_WIDTH-1:0] led_o
);

  localparam logic [2:0] SEL_VAL    = 3'd0;
  localparam logic [2:0] SEL_MODE   = 3'd1;
  localparam logic [2:0] SEL_PERIOD = 3'd2;
  localparam logic [2:0] SEL_RST    = 3'd3;
  localparam logic [2:0] SEL_STATUS = 3'd4;

  logic [LED_WIDTH-1:0] led_val_q, led_val_d;
  logic                 blink_en_q, blink_en_d;
  logic [31:0]          period_q, period_d;
  logic [31:0]          cnt_q, cnt_d;
  logic                 phase_q, phase_d;
  logic [31:0]          cnt_last;
  logic [2:0]           reg_sel;
  logic                 unused_addr_bits;

  assign reg_sel          = addr_i[4:2];
  assign unused_addr_bits = ^{addr_i[31:5], addr_i[1:0]};

  // A programmed period of 0 behaves as 1, so the wrap point is never below 0.
  assign cnt_last = (period_q == 32'd0) ? 32'd0 : period_q - 32'd1;

  always_comb begin
    led_val_d  = led_val_q;
    blink_en_d = blink_en_q;
    period_d   = period_q;
    cnt_d      = cnt_q;
    phase_d    = phase_q;

    if (blink_en_q) begin
      if (cnt_q == cnt_last) begin
        cnt_d   = 32'd0;
        phase_d = ~phase_q;
      end else begin
        cnt_d = cnt_q + 32'd1;
      end
    end else begin
      cnt_d   = 32'd0;
      phase_d = 1'b1;
    end

    // Register writes override the free-running blink update above.
    if (we_i) begin
      case (reg_sel)
        SEL_VAL: led_val_d = wdata_i[LED_WIDTH-1:0];
        SEL_MODE: begin
          blink_en_d = wdata_i[0];
          cnt_d      = 32'd0;
          phase_d    = 1'b1;
        end
        SEL_PERIOD: begin
          period_d = wdata_i;
          cnt_d    = 32'd0;
          phase_d  = 1'b1;
        end
        SEL_RST: begin
          if (wdata_i[0]) begin
            led_val_d  = '0;
            blink_en_d = 1'b0;
            period_d   = BLINK_PERIOD_RST;
            cnt_d      = 32'd0;
            phase_d    = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      led_val_q  <= '0;
      blink_en_q <= 1'b0;
      period_q   <= BLINK_PERIOD_RST;
      cnt_q      <= 32'd0;
      phase_q    <= 1'b1;
    end else begin
      led_val_q  <= led_val_d;
      blink_en_q <= blink_en_d;
      period_q   <= period_d;
      cnt_q      <= cnt_d;
      phase_q    <= phase_d;
    end
  end

  always_comb begin
    rdata_o = 32'd0;
    case (reg_sel)
      SEL_VAL:    rdata_o = 32'(led_val_q);
      SEL_MODE:   rdata_o = {31'd0, blink_en_q};
      SEL_PERIOD: rdata_o = period_q;
      SEL_STATUS: rdata_o = {31'd0, phase_q};
      default:    rdata_o = 32'd0;
    endcase
  end

  assign led_o = phase_q ? led_val_q : '0;

endmodule

// File: tb/tb_leds_controller.sv
// tb/tb_leds_controller.sv - vector table, blink corner sequences and a
// randomized run against a cycles-since-restart reference model.
module tb_leds_controller;

  localparam logic [31:0] PRST = 32'd10_000_000;
  localparam logic [31:0] BASE = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        arstn = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = BASE;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic [15:0] led;

  int n_checks = 0;
  int n_pass   = 0;

  leds_controller #(.LED_WIDTH(16), .BLINK_PERIOD_RST(PRST)) dut (
    .clk_i(clk), .arstn_i(arstn), .we_i(we), .addr_i(addr),
    .wdata_i(wdata), .rdata_o(rdata), .led_o(led)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    we = 1'b1; addr = a; wdata = d;
    @(posedge clk);
    #1 we = 1'b0;
  endtask

  task automatic rd_check(input string name, input logic [31:0] a, input logic [31:0] exp);
    addr = a;
    #1 check(name, rdata, exp);
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic [15:0] exp_led;
  } vec_t;

  vec_t vecs[21];

  // Reference model: blinking is described as elapsed cycles since the last restart.
  logic [15:0] m_val;
  logic        m_en;
  logic [31:0] m_per;
  longint      m_t;

  function automatic logic m_phase();
    longint p;
    p = (m_per == 32'd0) ? 1 : longint'(m_per);
    return ((m_t / p) % 2) == 0;
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    case ((a & 32'h1C) >> 2)
      0: return {16'd0, m_val};
      1: return {31'd0, m_en};
      2: return m_per;
      4: return {31'd0, m_phase()};
      default: return 32'd0;
    endcase
  endfunction

  task automatic m_reset();
    m_val = 16'd0; m_en = 1'b0; m_per = PRST; m_t = 0;
  endtask

  task automatic m_step(input logic w, input logic [31:0] a, input logic [31:0] d);
    if (m_en) m_t = m_t + 1;
    else m_t = 0;
    if (w) begin
      case ((a & 32'h1C) >> 2)
        0: m_val = d[15:0];
        1: begin m_en = d[0]; m_t = 0; end
        2: begin m_per = d; m_t = 0; end
        3: if (d[0]) m_reset();
        default: ;
      endcase
    end
  endtask

  initial begin
    vecs[0]  = '{1'b0, BASE + 32'h08, 32'h0,         PRST,          16'h0};
    vecs[1]  = '{1'b0, BASE + 32'h10, 32'h0,         32'd1,         16'h0};
    vecs[2]  = '{1'b0, BASE + 32'h00, 32'h0,         32'd0,         16'h0};
    vecs[3]  = '{1'b1, BASE + 32'h00, 32'hDEAD_A5A5, 32'd0,         16'h0};
    vecs[4]  = '{1'b0, BASE + 32'h00, 32'h0,         32'h0000_A5A5, 16'hA5A5};
    vecs[5]  = '{1'b1, BASE + 32'h03, 32'h0000_1234, 32'h0000_A5A5, 16'hA5A5};
    vecs[6]  = '{1'b0, BASE + 32'h01, 32'h0,         32'h0000_1234, 16'h1234};
    vecs[7]  = '{1'b1, BASE + 32'h14, 32'hFFFF_FFFF, 32'd0,         16'h1234};
    vecs[8]  = '{1'b0, BASE + 32'h14, 32'h0,         32'd0,         16'h1234};
    vecs[9]  = '{1'b0, BASE + 32'h1C, 32'h0,         32'd0,         16'h1234};
    vecs[10] = '{1'b1, BASE + 32'h10, 32'h0,         32'd1,         16'h1234};
    vecs[11] = '{1'b0, BASE + 32'h10, 32'h0,         32'd1,         16'h1234};
    vecs[12] = '{1'b1, BASE + 32'h0C, 32'h0,         32'd0,         16'h1234};
    vecs[13] = '{1'b0, BASE + 32'h00, 32'h0,         32'h0000_1234, 16'h1234};
    vecs[14] = '{1'b1, BASE + 32'h04, 32'hFFFF_FFFE, 32'd0,         16'h1234};
    vecs[15] = '{1'b0, BASE + 32'h04, 32'h0,         32'd0,         16'h1234};
    vecs[16] = '{1'b1, BASE + 32'h08, 32'h1234_5678, PRST,          16'h1234};
    vecs[17] = '{1'b0, BASE + 32'h08, 32'h0,         32'h1234_5678, 16'h1234};
    vecs[18] = '{1'b1, BASE + 32'h0C, 32'h0000_0001, 32'd0,         16'h1234};
    vecs[19] = '{1'b0, BASE + 32'h08, 32'h0,         PRST,          16'h0};
    vecs[20] = '{1'b0, BASE + 32'h00, 32'h0,         32'd0,         16'h0};

    repeat (2) @(negedge clk);
    check("reset_led", {16'd0, led}, 32'd0);
    arstn = 1'b1;

    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      we = vecs[i].we; addr = vecs[i].addr; wdata = vecs[i].wdata;
      #1;
      check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
      check($sformatf("vec%0d_led", i), {16'd0, led}, {16'd0, vecs[i].exp_led});
      @(posedge clk);
      #1 we = 1'b0;
    end

    wr(BASE + 32'h00, 32'h0000_00FF);
    wr(BASE + 32'h08, 32'd3);
    wr(BASE + 32'h04, 32'd1);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check($sformatf("blink3_c%0d", i), {16'd0, led}, ((i / 3) % 2 == 0) ? 32'hFF : 32'h0);
    end

    wr(BASE + 32'h08, 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("blink0_c%0d", i), {16'd0, led}, (i % 2 == 0) ? 32'hFF : 32'h0);
    end

    wr(BASE + 32'h08, 32'd3);
    for (int i = 0; i < 4; i++) @(negedge clk);
    check("restart_pre_off", {16'd0, led}, 32'h0);
    wr(BASE + 32'h08, 32'd5);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("restart5_c%0d", i), {16'd0, led}, (i < 5) ? 32'hFF : 32'h0);
    end

    wr(BASE + 32'h0C, 32'd1);
    @(negedge clk);
    check("ledrst_led", {16'd0, led}, 32'h0);
    rd_check("ledrst_val", BASE + 32'h00, 32'd0);
    rd_check("ledrst_mode", BASE + 32'h04, 32'd0);
    rd_check("ledrst_period", BASE + 32'h08, PRST);
    rd_check("ledrst_status", BASE + 32'h10, 32'd1);
    rd_check("ledrst_rd0c", BASE + 32'h0C, 32'd0);

    wr(BASE + 32'h00, 32'h0000_00FF);
    wr(BASE + 32'h08, 32'd2);
    wr(BASE + 32'h04, 32'd1);
    check("async_pre_led", {16'd0, led}, 32'hFF);
    #2 arstn = 1'b0;
    #1 check("async_led_noedge", {16'd0, led}, 32'h0);
    @(negedge clk);
    arstn = 1'b1;
    rd_check("async_mode", BASE + 32'h04, 32'd0);
    rd_check("async_period", BASE + 32'h08, PRST);
    repeat (3) @(negedge clk);
    check("async_led_after", {16'd0, led}, 32'h0);

    arstn = 1'b0;
    @(negedge clk);
    arstn = 1'b1;
    m_reset();
    for (int c = 0; c < 2000; c++) begin
      logic        w;
      logic [2:0]  off;
      logic [31:0] a, d;
      @(negedge clk);
      w   = ($urandom_range(0, 2) == 0);
      off = 3'($urandom_range(0, 7));
      a   = BASE | (32'(off) << 2) | 32'($urandom_range(0, 3));
      d   = $urandom;
      if (off == 3'd2) d = (($urandom_range(0, 15) == 0) ? 32'd40 : 32'($urandom_range(0, 6)));
      if (off == 3'd3) d = {d[31:1], ($urandom_range(0, 7) == 0)};
      if (off == 3'd1) d = {d[31:1], ($urandom_range(0, 3) != 0)};
      we = w; addr = a; wdata = d;
      #1;
      check("rand_rdata", rdata, m_read(a));
      check("rand_led", {16'd0, led}, {16'd0, (m_phase() ? m_val : 16'd0)});
      @(posedge clk);
      m_step(w, a, d);
    end
    @(negedge clk);
    we = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
